// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand/result handshake bundle for wallace_mult_pipe (acc_clr present only with WALLACE_MAC_EN)
interface wallace_mult_pipe_if #(parameter int WIDTH = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
`ifdef WALLACE_MAC_EN
  logic             acc_clr;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_data;
  modport master (
    output in_valid, a, b, sgn,
`ifdef WALLACE_MAC_EN
    output acc_clr,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, a, b, sgn,
`ifdef WALLACE_MAC_EN
    input  acc_clr,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Baugh-Wooley/Wallace multiplier with optional low-column truncation; WALLACE_MAC_EN adds an output accumulator
module wallace_mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 3,
  parameter int APPROX      = 0
) (
  input logic            clk,
  input logic            rst,
  wallace_mult_pipe_if.slave s
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam logic [PW-1:0] KEEP = ~((PW'(1) << APPROX) - PW'(1));
  localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
  logic             en;
  logic             rv, rsg;
  logic [WIDTH-1:0] ra, rb;
`ifdef WALLACE_MAC_EN
  logic             rclr, lclr;
`endif
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    rows [NR];
  logic [PW-1:0]    nxt  [NR];
  int               n, m;
  logic [PW-1:0]    cs_s, cs_c, ls, lc;
  logic             lv;
  assign en         = ~s.out_valid | s.out_ready;
  assign s.in_ready = en;
  // operand capture rank: one item accepted per enabled edge
  always_ff @(posedge clk)
    if (rst) rv <= 1'b0;
    else if (en) begin
      rv  <= s.in_valid;
      ra  <= s.a;
      rb  <= s.b;
      rsg <= s.sgn;
`ifdef WALLACE_MAC_EN
      rclr <= s.acc_clr;
`endif
    end
  // partial products (BW inversions + correction row, low columns dropped) reduced by 3:2 levels to two rows
  always_comb begin
    pp = '0;
    n  = NR;
    m  = 0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++)
        pp[i] = (ra[i] & rb[j]) ^ (rsg & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      rows[j] = (PW'(pp) << j) & KEEP;
    end
    rows[WIDTH] = rsg ? CORR : '0;
    nxt = rows;
    for (int l = 0; l < NR; l++)
      if (n > 2) begin
        nxt = rows;
        m   = 0;
        for (int i = 0; i < NR; i++)
          if (i % 3 == 2 && i < n) begin
            nxt[m]     = rows[i-2] ^ rows[i-1] ^ rows[i];
            nxt[m + 1] = ((rows[i-2] & rows[i-1]) | (rows[i-2] & rows[i]) | (rows[i-1] & rows[i])) << 1;
            m          = m + 2;
          end else if (i >= n - n % 3 && i < n) begin
            nxt[m] = rows[i];
            m      = m + 1;
          end
        rows = nxt;
        n    = m;
      end
    cs_s = rows[0];
    cs_c = (n > 1) ? rows[1] : '0;
  end
  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign ls = cs_s;
      assign lc = cs_c;
      assign lv = rv;
`ifdef WALLACE_MAC_EN
      assign lclr = rclr;
`endif
    end else begin : g_pipe
      logic [PW-1:0]          ps [PIPE_STAGES-1];
      logic [PW-1:0]          pc [PIPE_STAGES-1];
      logic [PIPE_STAGES-2:0] pv;
`ifdef WALLACE_MAC_EN
      logic [PIPE_STAGES-2:0] pclr;
`endif
      // carry-save ranks between reduction and the final adder
      always_ff @(posedge clk)
        if (rst) pv <= '0;
        else if (en) begin
          ps[0] <= cs_s;
          pc[0] <= cs_c;
          pv[0] <= rv;
`ifdef WALLACE_MAC_EN
          pclr[0] <= rclr;
`endif
          for (int k = 1; k < PIPE_STAGES - 1; k++) begin
            ps[k] <= ps[k-1];
            pc[k] <= pc[k-1];
            pv[k] <= pv[k-1];
`ifdef WALLACE_MAC_EN
            pclr[k] <= pclr[k-1];
`endif
          end
        end
      assign ls = ps[PIPE_STAGES-2];
      assign lc = pc[PIPE_STAGES-2];
      assign lv = pv[PIPE_STAGES-2];
`ifdef WALLACE_MAC_EN
      assign lclr = pclr[PIPE_STAGES-2];
`endif
    end
  endgenerate
  // output rank: final carry-propagate add (into the accumulator when enabled)
  always_ff @(posedge clk)
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
    end else if (en) begin
      s.out_valid <= lv;
`ifdef WALLACE_MAC_EN
      if (lv) s.out_data <= (lclr ? '0 : s.out_data) + ls + lc;
`else
      if (lv) s.out_data <= ls + lc;
`endif
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed bench with an arithmetic reference model for exact and APPROX=4 instances
module tb_wallace_mult_pipe;
  localparam int W = 16;
  localparam int P = 3;
  typedef struct {
    logic [W-1:0] x, y;
    logic         s, c;
    logic [31:0]  le, la;
    logic         he, ha;
    int           t;
  } item_t;
  typedef struct {
    logic [W-1:0] x, y;
    logic         s;
    logic [31:0]  le;
  } vec_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, sgn = 0, clr = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic [31:0] lit_e = '0, lit_a = '0;
  logic has_e = 0, has_a = 0, chk_lat = 0;
  int total = 0, bad = 0, cyc = 0;
  item_t q[$];
  item_t it;
  logic [31:0] acc_e = '0, acc_a = '0, pe, pa, held_d = '0;
  logic held = 0;
  vec_t vecs [7];
  wallace_mult_pipe_if #(.WIDTH(W)) bx ();
  wallace_mult_pipe_if #(.WIDTH(W)) ba ();
  assign bx.in_valid = in_valid;
  assign bx.a = a;
  assign bx.b = b;
  assign bx.sgn = sgn;
  assign bx.out_ready = out_ready;
  assign ba.in_valid = in_valid;
  assign ba.a = a;
  assign ba.b = b;
  assign ba.sgn = sgn;
  assign ba.out_ready = out_ready;
`ifdef WALLACE_MAC_EN
  assign bx.acc_clr = clr;
  assign ba.acc_clr = clr;
`endif
  wallace_mult_pipe #(.WIDTH(W), .PIPE_STAGES(P), .APPROX(0)) dut (.clk(clk), .rst(rst), .s(bx.slave));
  wallace_mult_pipe #(.WIDTH(W), .PIPE_STAGES(P), .APPROX(4)) dut4 (.clk(clk), .rst(rst), .s(ba.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // true product minus the value of every a[i]b[j] term whose column i+j is below k
  function automatic logic [31:0] model(input logic [W-1:0] x, y, input logic s, input int k);
    longint px, py, p;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    p  = px * py;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j < k && x[i] && y[j]) p = p - (longint'(1) << (i + j));
    return p[31:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_e = '0;
      acc_a = '0;
      held = 0;
    end else begin
      chk("in_ready", {31'b0, bx.in_ready}, {31'b0, !bx.out_valid || out_ready});
      if (held) chk("stall_hold", bx.out_data, held_d);
      if (bx.out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious: got output %h expected none", bx.out_data);
        end else begin
          it = q.pop_front();
          pe = model(it.x, it.y, it.s, 0);
          pa = model(it.x, it.y, it.s, 4);
`ifdef WALLACE_MAC_EN
          acc_e = (it.c ? 32'd0 : acc_e) + pe;
          acc_a = (it.c ? 32'd0 : acc_a) + pa;
          pe = acc_e;
          pa = acc_a;
`endif
          chk("exact", bx.out_data, pe);
          chk("approx", ba.out_data, pa);
          if (it.he) chk("lit_exact", bx.out_data, it.le);
          if (it.ha) chk("lit_approx", ba.out_data, it.la);
          if (chk_lat) chk("latency", 32'(cyc - it.t - 1), P);
        end
      end
      held = bx.out_valid && !out_ready;
      held_d = bx.out_data;
      if (in_valid && bx.in_ready) q.push_back('{a, b, sgn, clr, lit_e, lit_a, has_e, has_a, cyc});
    end
  end
  task automatic send(input logic [W-1:0] x, y, input logic s, c,
                      input logic [31:0] le, la, input logic he, ha);
    logic done;
    a = x; b = y; sgn = s; clr = c;
    lit_e = le; lit_a = la; has_e = he; has_a = ha;
    in_valid = 1;
    done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = bx.in_ready;
      @(posedge clk);
    end
    #1;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle();
    in_valid = 0;
    has_e = 0;
    has_a = 0;
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && q.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached limit 500000", $time);
    $fatal(1);
  end
  initial begin
    vecs[0] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[1] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE};
    vecs[2] = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE};
    vecs[3] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[6] = '{16'h1234, 16'h0010, 1'b0, 32'h0001_2340};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bx.out_valid}, 32'd0);
    chk("rst_out_data", bx.out_data, 32'd0);
    chk("rst_in_ready", {31'b0, bx.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk_lat = 1;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        send(16'((i * 331) & 1023), 16'((j * 557) & 1023), 0, 0, 0, 0, 0, 0);
    send(16'd1023, 16'd1023, 0, 0, 32'd1046529, 0, 1, 0);
    send(16'd0, 16'd1023, 0, 0, 32'd0, 0, 1, 0);
    idle();
    drain();
    chk_lat = 0;
    for (int i = 0; i < 7; i++) send(vecs[i].x, vecs[i].y, vecs[i].s, 1, vecs[i].le, 0, 1, 0);
    send(16'h000F, 16'h000F, 0, 1, 32'h0000_00E1, 32'h0000_00B0, 1, 1);
    idle();
    drain();
    fork
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 0;
        repeat (4) @(posedge clk);
        #2 out_ready = 1;
      end
    join_none
    for (int k = 1; k <= 5; k++) send(16'(k), 16'(k + 1), 0, 0, 0, 0, 0, 0);
    idle();
    drain();
    send(16'd100, 16'd200, 0, 1, 0, 0, 0, 0);
    send(16'd300, 16'd400, 0, 0, 0, 0, 0, 0);
    idle();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_valid", {31'b0, bx.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h0010, 0, 1, 32'h0001_2340, 0, 1, 0);
    idle();
    drain();
`ifdef WALLACE_MAC_EN
    send(16'd3, 16'd4, 0, 1, 32'd12, 0, 1, 0);
    send(16'd5, 16'd6, 0, 0, 32'd42, 0, 1, 0);
    send(16'd7, 16'd8, 0, 0, 32'd98, 0, 1, 0);
    send(16'd2, 16'd2, 0, 1, 32'd4, 0, 1, 0);
`else
    send(16'd3, 16'd4, 0, 1, 32'd12, 0, 1, 0);
    send(16'd5, 16'd6, 0, 0, 32'd30, 0, 1, 0);
    send(16'd7, 16'd8, 0, 0, 32'd56, 0, 1, 0);
    send(16'd2, 16'd2, 0, 1, 32'd4, 0, 1, 0);
`endif
    idle();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
